// File: rtl/arb_pkg.sv
// Shared constants and FSM state type for the 16-way round-robin arbiter.
package arb_pkg;

    localparam int NREQ  = 16;
    localparam int IDX_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/decoder4_16.sv
// 4-to-16 one-hot decoder with enable; all outputs low when disabled.
module decoder4_16 (
    input  logic [3:0]  w,
    input  logic        en,
    output logic [15:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[w] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter for 16 requesters with a programmable hold limit per tenure.
// Back-to-back handover: the ended owner is masked out of the same-cycle re-pick.
module rr_arbiter16
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic                release_i,   // owner finished; `release` is a reserved word
    output logic                gnt_valid,
    output logic [IDX_W-1:0]    gnt_idx,
    output logic [NREQ-1:0]     gnt_onehot,
    output logic                timeout
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    // First set bit of r scanning p, p+1, ... with 4-bit wrap; MSB flags a hit.
    function automatic logic [IDX_W:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [IDX_W-1:0] p);
        logic             found;
        logic [IDX_W-1:0] k;
        logic [IDX_W-1:0] win;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NREQ; i++) begin
            k = p + IDX_W'(i);
            if (!found && r[k]) begin
                found = 1'b1;
                win   = k;
            end
        end
        return {found, win};
    endfunction

    arb_state_e       state_q,     state_d;
    logic [IDX_W-1:0] gnt_idx_q,   gnt_idx_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic [IDX_W-1:0] ptr_q,       ptr_d;
    logic [7:0]       hold_cnt_q,  hold_cnt_d;
    logic             timeout_q,   timeout_d;

    logic             end_rel;
    logic             end_wd;
    logic             end_lim;
    logic [IDX_W-1:0] next_ptr;
    logic [NREQ-1:0]  masked_req;
    logic [IDX_W:0]   pick_idle;
    logic [IDX_W:0]   pick_next;

    always_comb begin
        end_rel    = release_i;
        end_wd     = !req[gnt_idx_q];
        end_lim    = (hold_cnt_q == HOLD_LAST);
        next_ptr   = gnt_idx_q + IDX_W'(1);
        masked_req = req & ~(NREQ'(1) << gnt_idx_q);
        pick_idle  = rr_pick(req, ptr_q);
        pick_next  = rr_pick(masked_req, next_ptr);
    end

    always_comb begin
        // NOTE: every *_d gets a default first, so no path through this block can infer a latch.
        state_d     = state_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        timeout_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_idle[IDX_W]) begin
                    gnt_idx_d   = pick_idle[IDX_W-1:0];
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                if (end_rel || end_wd || end_lim) begin
                    ptr_d     = next_ptr;
                    timeout_d = end_lim && !end_rel && !end_wd;
                    if (pick_next[IDX_W]) begin
                        gnt_idx_d  = pick_next[IDX_W-1:0];
                        hold_cnt_d = '0;
                    end else begin
                        gnt_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gnt_valid = gnt_valid_q;
    assign gnt_idx   = gnt_idx_q;
    assign timeout   = timeout_q;

    decoder4_16 u_dec (
        .w  (gnt_idx_q),
        .en (gnt_valid_q),
        .y  (gnt_onehot)
    );

endmodule

// File: tb/tb_rr_arbiter16.sv
// Directed bench for rr_arbiter16 (MAX_HOLD=4): a vector table plus a timeout-rotation sequence.
module tb_rr_arbiter16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic        release_i;
    logic        gnt_valid;
    logic [3:0]  gnt_idx;
    logic [15:0] gnt_onehot;
    logic        timeout;

    int n_checks = 0;
    int n_errors = 0;

    rr_arbiter16 #(.MAX_HOLD(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .release_i  (release_i),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx),
        .gnt_onehot (gnt_onehot),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [15:0] req;
        logic        rel;
        logic        exp_valid;
        logic [3:0]  exp_idx;
        logic        exp_timeout;
    } vec_t;

    vec_t vecs[64];
    int   nv = 0;

    task automatic add(input logic r, input logic [15:0] q, input logic l,
                       input logic ev, input logic [3:0] ei, input logic et);
        vecs[nv] = '{rst: r, req: q, rel: l, exp_valid: ev, exp_idx: ei, exp_timeout: et};
        nv++;
    endtask

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic check_outputs(input string tag, input logic ev, input logic [3:0] ei, input logic et);
        logic [15:0] exp_oh;
        exp_oh = ev ? (16'd1 << ei) : 16'd0;
        check({tag, " gnt_valid"}, 32'(gnt_valid), 32'(ev));
        check({tag, " gnt_onehot"}, 32'(gnt_onehot), 32'(exp_oh));
        check({tag, " timeout"}, 32'(timeout), 32'(et));
        if (ev) check({tag, " gnt_idx"}, 32'(gnt_idx), 32'(ei));
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        release_i = 1'b0;

        // Reset, then single requester 3 held: 4-cycle tenure, timeout, one idle cycle, regrant.
        add(1, 16'h0000, 0, 0, 0,  0);
        add(0, 16'h0008, 0, 1, 3,  0);
        add(0, 16'h0008, 0, 1, 3,  0);
        add(0, 16'h0008, 0, 1, 3,  0);
        add(0, 16'h0008, 0, 1, 3,  0);
        add(0, 16'h0008, 0, 0, 0,  1);
        add(0, 16'h0008, 0, 1, 3,  0);
        add(1, 16'h0000, 0, 0, 0,  0);
        // Rotation 0/15 with release each cycle.
        add(0, 16'h8001, 0, 1, 0,  0);
        add(0, 16'h8001, 1, 1, 15, 0);
        add(0, 16'h8001, 1, 1, 0,  0);
        add(0, 16'h8001, 1, 1, 15, 0);
        add(0, 16'h8001, 1, 1, 0,  0);
        // Grant 13 so ptr lands on 14, then wrap order 14, 0, 1.
        add(0, 16'h2000, 1, 1, 13, 0);
        add(0, 16'h4003, 1, 1, 14, 0);
        add(0, 16'h4003, 1, 1, 0,  0);
        add(0, 16'h4003, 1, 1, 1,  0);
        // Owner 1 withdraws -> 5; owner 5 withdraws -> 9, no timeout.
        add(0, 16'h0220, 0, 1, 5,  0);
        add(0, 16'h0200, 0, 1, 9,  0);
        add(0, 16'h0200, 0, 1, 9,  0);
        add(0, 16'h0200, 0, 1, 9,  0);
        add(0, 16'h0200, 0, 1, 9,  0);
        // Release coincident with hold limit: no timeout.
        add(0, 16'h0200, 1, 0, 0,  0);
        // Grant 7, reach hold_cnt=2, reset mid-tenure, then ptr back at 0.
        add(0, 16'h0080, 0, 1, 7,  0);
        add(0, 16'h0080, 0, 1, 7,  0);
        add(0, 16'h0080, 0, 1, 7,  0);
        add(1, 16'h0080, 0, 0, 0,  0);
        add(0, 16'h0081, 0, 1, 0,  0);
        // Release while idle is ignored.
        add(0, 16'h0000, 1, 0, 0,  0);
        add(0, 16'h0000, 1, 0, 0,  0);
        add(0, 16'h0100, 1, 1, 8,  0);

        for (int i = 0; i < nv; i++) begin
            rst       = vecs[i].rst;
            req       = vecs[i].req;
            release_i = vecs[i].rel;
            @(posedge clk);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_idx, vecs[i].exp_timeout);
        end

        // Two requesters held: hold limit forces handover with timeout and no idle bubble.
        rst = 1'b1; req = '0; release_i = 1'b0;
        @(posedge clk);
        #1;
        check_outputs("seq_reset", 1'b0, 4'd0, 1'b0);
        rst = 1'b0;
        req = 16'h0003;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk);
            #1;
            check_outputs($sformatf("seq_to%0d", n), 1'b1, 4'(((n - 1) / 4) % 2),
                          (n == 5) || (n == 9));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
